// File: rtl/muldiv32.sv
// muldiv32: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[0]); otherwise every op is unsigned.
module muldiv32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic [WIDTH-1:0]     m, s_mag, t_mag, hi_fix, lo_fix;
    logic [2*WIDTH-1:0]   p, p_next;
    logic [WIDTH:0]       sum, shifted, diff;
    logic                 accept, dz;

    assign accept = (state == IDLE) && start;
    assign dz     = op[1] && (T == '0);
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    // p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    assign shifted = p[2*WIDTH-1:WIDTH-1];
    assign diff    = shifted - {1'b0, m};
    assign p_next  = !is_div ? {sum, p[WIDTH-1:1]} :
                     diff[WIDTH] ? {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0} :
                                   {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

`ifdef MULDIV_SIGNED_EN
    logic               in_s, in_t, s_neg, t_neg;
    logic [2*WIDTH-1:0] prod_fix;
    assign in_s     = op[0] & S[WIDTH-1];
    assign in_t     = op[0] & T[WIDTH-1];
    assign s_mag    = in_s ? -S : S;
    assign t_mag    = in_t ? -T : T;
    assign prod_fix = (s_neg ^ t_neg) ? -p : p;
    assign lo_fix   = is_div ? ((s_neg ^ t_neg) ? -p[WIDTH-1:0] : p[WIDTH-1:0]) : prod_fix[WIDTH-1:0];
    assign hi_fix   = is_div ? (s_neg ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH]) : prod_fix[2*WIDTH-1:WIDTH];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_neg <= 1'b0;
            t_neg <= 1'b0;
        end else if (accept) begin
            s_neg <= in_s;
            t_neg <= in_t;
        end
    end
`else
    logic unused_op;
    assign unused_op = op[0];
    assign s_mag     = S;
    assign t_mag     = T;
    assign hi_fix    = p[2*WIDTH-1:WIDTH];
    assign lo_fix    = p[WIDTH-1:0];
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = dz ? DONE : RUN;
            RUN:  if (cnt == CNT_LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            m           <= '0;
            p           <= '0;
            HI          <= '0;
            LO          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt         <= '0;
                is_div      <= op[1];
                m           <= op[1] ? t_mag : s_mag;
                p           <= {{WIDTH{1'b0}}, op[1] ? s_mag : t_mag};
                div_by_zero <= dz;
                if (dz) begin
                    HI <= S;
                    LO <= '1;
                end
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                p   <= p_next;
            end else if (state == FIX) begin
                HI <= hi_fix;
                LO <= lo_fix;
            end
        end
    end
endmodule

// File: tb/tb_muldiv32.sv
// tb_muldiv32: scoreboard bench for muldiv32; expected results come from plain integer arithmetic.
module tb_muldiv32;
    localparam int W = 32;

    logic         clk = 0, reset = 0, start = 0;
    logic [1:0]   op = 0;
    logic [W-1:0] S = 0, T = 0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e, last_e;
    int   tests = 0, fails = 0, cyc = 0;

    muldiv32 dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .S(S), .T(T),
        .busy(busy), .done(done), .HI(HI), .LO(LO), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t);
        exp_t e;
        logic [63:0] p;
        bit sg;
`ifdef MULDIV_SIGNED_EN
        sg = o[0];
`else
        sg = 0;
`endif
        e.dz = 0;
        e.cyc = 0;
        e.hi = 0;
        e.lo = 0;
        if (!o[1]) begin
            if (sg) p = 64'(longint'($signed(s)) * longint'($signed(t)));
            else    p = {32'b0, s} * {32'b0, t};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (t == 0) begin
            e.hi = s;
            e.lo = '1;
            e.dz = 1;
        end else if (!sg) begin
            e.lo = s / t;
            e.hi = s % t;
        end else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 0;
        end else begin
            e.lo = 32'($signed(s) / $signed(t));
            e.hi = 32'($signed(s) % $signed(t));
        end
        return e;
    endfunction

    // call at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t, input bit push = 1);
        exp_t e;
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=1 after 100 cycles, required 0");
        end
        e = model(o, s, t);
        e.cyc = cyc + (e.dz ? 1 : 34);
        if (push) begin
            sbq.push_back(e);
            last_e = e;
        end
        op = o;
        S = s;
        T = t;
        start = 1;
        @(negedge clk);
        start = 0;
        S = $urandom;
        T = $urandom;
        op = 2'($urandom);
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: done=1 with no outstanding op, required 0");
            end else begin
                mon_e = sbq.pop_front();
                check("HI", HI, mon_e.hi);
                check("LO", LO, mon_e.lo);
                check("div_by_zero", div_by_zero, mon_e.dz);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] rs, rt;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_HI", HI, 0);
        check("rst_LO", LO, 0);
        check("rst_dz", div_by_zero, 0);
        reset = 1;
        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        issue(2'b10, 32'd100, 32'd7);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'd5, 32'd0);
        issue(2'b00, 32'd3, 32'd5);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'hFFFF_FFF0, 32'd0);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        issue(2'b11, 32'd7, 32'hFFFF_FFFE);
        // start pulsed mid-run must be dropped
        issue(2'b00, 32'h1234, 32'h5678);
        repeat (5) @(negedge clk);
        op = 2'b10;
        S = 32'd99;
        T = 32'd0;
        start = 1;
        @(negedge clk);
        start = 0;
        check("ignored_busy", busy, 1);
        // reset mid-operation, no result expected
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        repeat (9) @(posedge clk);
        #1 reset = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_HI", HI, 0);
        check("mid_rst_LO", LO, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd4);
        for (int i = 0; i < 60; i++) begin
            rs = $urandom;
            rt = $urandom;
            case ($urandom_range(0, 4))
                0: rt = 0;
                1: rt = $urandom_range(1, 9);
                2: rs = $urandom_range(0, 1000);
                default: ;
            endcase
            issue(2'($urandom), rs, rt);
        end
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
        end
        repeat (5) @(negedge clk);
        check("hold_HI", HI, last_e.hi);
        check("hold_LO", LO, last_e.lo);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
